mem_arbiter: RTL and testbench

- Shares one single-port unified memory between the core's instruction-fetch (IF) port and data-memory (DM) port.
- Lets the core move from ideal separate instruction and data memories to one real memory with variable latency.
- Arbitrates round-robin, sequences one outstanding transaction at a time over a req/ack memory handshake, and aborts hung accesses with a watchdog timeout.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_wdog.sv | 43 ++++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// mem_arb_pkg : shared types and helpers for the unified-memory arbiter
// Rev 1.0
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_wdog.sv
`default_nettype none
// ============================================================================
// mem_arb_wdog : busy-cycle counter that flags a hung memory access
// Rev 1.0
// ============================================================================
module mem_arb_wdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expire
);

    generate
        if (TIMEOUT > 0) begin : g_wdog_on
            localparam int CNT_W = $clog2(TIMEOUT + 1);
            localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_cnt <= '0;
                end else if (clr) begin
                    r_cnt <= '0;
                end else if (en) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            // Only a cycle that is still waiting (no ack) may expire.
            assign expire = en && (r_cnt == LAST);
        end else begin : g_wdog_off
            assign expire = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : round-robin IF/DM arbiter onto one req/ack memory port
// Rev 1.0
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int ADDR_W  = 32,
    parameter  int DATA_W  = 32,
    parameter  int TIMEOUT = 64,
    localparam int STRB_W  = strb_width(DATA_W)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [STRB_W-1:0] dm_wstrb,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t r_state;
    state_t w_next_state;
    logic   r_last_owner;
    logic   w_grant_if;
    logic   w_grant_dm;
    logic   w_busy;
    logic   w_expire;
    logic   w_done;

    assign w_busy = (r_state != IDLE);
    assign w_done = w_busy && (mem_ack || w_expire);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_grant_if   = 1'b0;
        w_grant_dm   = 1'b0;
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                // On a tie the port that did not own the last grant wins.
                if (dm_req && (!if_req || (r_last_owner == OWN_IF))) begin
                    w_grant_dm   = 1'b1;
                    w_next_state = BUSY_DM;
                end else if (if_req) begin
                    w_grant_if   = 1'b1;
                    w_next_state = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (mem_ack || w_expire) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Grants are combinational, so hold them off while reset is asserted.
    assign if_gnt = w_grant_if & rstn;
    assign dm_gnt = w_grant_dm & rstn;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last_owner <= OWN_IF;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_wstrb    <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            if_rvalid    <= 1'b0;
            if_rdata     <= '0;
            if_err       <= 1'b0;
            dm_rvalid    <= 1'b0;
            dm_rdata     <= '0;
            dm_err       <= 1'b0;
        end else begin
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            if (w_grant_dm) begin
                mem_req      <= 1'b1;
                mem_we       <= dm_we;
                mem_wstrb    <= dm_we ? dm_wstrb : '0;
                mem_addr     <= dm_addr;
                mem_wdata    <= dm_wdata;
                r_last_owner <= OWN_DM;
            end else if (w_grant_if) begin
                mem_req      <= 1'b1;
                mem_we       <= 1'b0;
                mem_wstrb    <= '0;
                mem_addr     <= if_addr;
                r_last_owner <= OWN_IF;
            end
            // An ack in the expiry cycle completes normally.
            if (w_done) begin
                mem_req <= 1'b0;
                if (r_state == BUSY_IF) begin
                    if_rvalid <= 1'b1;
                    if_rdata  <= mem_ack ? mem_rdata : '0;
                    if_err    <= !mem_ack;
                end else begin
                    dm_rvalid <= 1'b1;
                    dm_rdata  <= mem_ack ? mem_rdata : '0;
                    dm_err    <= !mem_ack;
                end
            end
        end
    end

    mem_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (w_grant_if | w_grant_dm),
        .en     (w_busy && !mem_ack),
        .expire (w_expire)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : vector table, directed corner cases and random traffic
// Rev 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_req, if_gnt, if_rvalid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid, dm_err;
    logic [3:0]  dm_wstrb, mem_wstrb;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;
    int force_ackc;
    logic inject_ack;
    int ack_cnt = 0;
    int lat;
    logic last_dm = 1'b0;

    logic [31:0] phys_mem [logic [31:0]];
    logic [31:0] ref_mem  [logic [31:0]];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) u_dut (
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_wstrb(dm_wstrb), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
        .dm_rdata(dm_rdata), .dm_err(dm_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Number of mem_req-high cycles before the memory acks this address.
    function automatic int ack_cyc(input logic [31:0] a);
        return int'((a >> 2) % 32'd10) + 1;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // Memory responder with variable latency.
    always @(posedge clk) begin
        #1;
        if (mem_req) ack_cnt = ack_cnt + 1; else ack_cnt = 0;
        lat = (force_ackc != 0) ? force_ackc : ack_cyc(mem_addr);
        if (mem_req && ack_cnt == lat) begin
            mem_ack   = 1'b1;
            mem_rdata = phys_rd(mem_addr);
            if (mem_we) phys_mem[mem_addr] = merge(phys_rd(mem_addr), mem_wdata, mem_wstrb);
        end else if (inject_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = $urandom;
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
        end
    end

    // Round-robin rule, mutual exclusion and idle-only grants.
    always @(negedge clk) begin
        if (!rstn) begin
            last_dm = 1'b0;
        end else if (if_gnt || dm_gnt) begin
            chk("mon_excl", {if_gnt, dm_gnt}, {1'b0, dm_gnt} | {dm_gnt ? 1'b0 : 1'b1, 1'b0});
            if (if_req && dm_req) chk("mon_rr", dm_gnt, !last_dm);
            chk("mon_idle_req", mem_req, 1'b0);
            last_dm = dm_gnt;
        end
    end

    typedef struct {
        logic        ifr;
        logic        dmr;
        logic [31:0] ia;
        logic [31:0] da;
        logic        own_dm;
        int          ackc;
        logic        err;
    } vec_t;

    vec_t tbl [10];

    task automatic if_proc(input int n);
        logic [31:0] a;
        int w;
        logic e;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk); #1;
            a = 32'h1000_0000 + 32'($urandom_range(0, 63)) * 4;
            if_req = 1'b1; if_addr = a;
            w = 0;
            @(negedge clk);
            while (!if_gnt && w < 200) begin @(negedge clk); w++; end
            chk("rnd_if_gnt_wait", if_gnt, 1'b1);
            @(posedge clk); #1; if_req = 1'b0;
            w = 0;
            @(negedge clk);
            while (!if_rvalid && w < 40) begin @(negedge clk); w++; end
            chk("rnd_if_rvalid", if_rvalid, 1'b1);
            e = (ack_cyc(a) > TO);
            chk("rnd_if_err", if_err, e);
            chk("rnd_if_rdata", if_rdata, e ? 32'h0 : init_word(a));
        end
    endtask

    task automatic dm_proc(input int n);
        logic [31:0] a, d;
        logic [3:0] s;
        logic we, e;
        int w;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk); #1;
            a  = 32'h2000_0000 + 32'($urandom_range(0, 15)) * 4;
            we = 1'($urandom_range(0, 1));
            s  = 4'($urandom_range(1, 15));
            d  = $urandom;
            dm_req = 1'b1; dm_addr = a; dm_we = we; dm_wstrb = s; dm_wdata = d;
            w = 0;
            @(negedge clk);
            while (!dm_gnt && w < 200) begin @(negedge clk); w++; end
            chk("rnd_dm_gnt_wait", dm_gnt, 1'b1);
            @(posedge clk); #1; dm_req = 1'b0;
            w = 0;
            @(negedge clk);
            while (!dm_rvalid && w < 40) begin @(negedge clk); w++; end
            chk("rnd_dm_rvalid", dm_rvalid, 1'b1);
            e = (ack_cyc(a) > TO);
            chk("rnd_dm_err", dm_err, e);
            if (!we) chk("rnd_dm_rdata", dm_rdata, e ? 32'h0 : ref_rd(a));
            else if (!e) ref_mem[a] = merge(ref_rd(a), d, s);
        end
    endtask

    initial begin : main
        int n, cnt;
        logic seen_if, got_dm;
        rstn = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_wstrb = '0; dm_addr = '0; dm_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        force_ackc = 0; inject_ack = 1'b0;

        tbl[0] = '{1'b1, 1'b1, 32'h1000_0104, 32'h2000_0204, 1'b1, 4, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 32'h1000_0108, 32'h2000_0208, 1'b0, 1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 32'h1000_010C, 32'h2000_020C, 1'b1, 2, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 32'h1000_0110, 32'h2000_0210, 1'b0, 3, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 32'h1000_0114, 32'h2000_0214, 1'b0, 5, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 32'h1000_0118, 32'h2000_0218, 1'b1, 6, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 32'h1000_011C, 32'h2000_021C, 1'b1, 7, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 32'h1000_0120, 32'h2000_0220, 1'b0, 2, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 32'h1000_0124, 32'h2000_0224, 1'b1, 9, 1'b1};
        tbl[9] = '{1'b1, 1'b0, 32'h1000_0128, 32'h2000_0228, 1'b0, 8, 1'b0};

        // Reset state, grants suppressed during reset.
        repeat (2) @(posedge clk);
        #2; if_req = 1'b1; dm_req = 1'b1;
        #1;
        chk("rst_if_gnt", if_gnt, 1'b0);
        chk("rst_dm_gnt", dm_gnt, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_rvalids", {if_rvalid, dm_rvalid, if_err, dm_err}, 4'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        if_req = 1'b0; dm_req = 1'b0;
        @(posedge clk); #3; rstn = 1'b1;

        // Table of single transactions.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if_req = tbl[i].ifr; if_addr = tbl[i].ia;
            dm_req = tbl[i].dmr; dm_addr = tbl[i].da; dm_we = 1'b0; dm_wstrb = 4'hF;
            force_ackc = tbl[i].ackc;
            #1;
            chk("tbl_if_gnt", if_gnt, !tbl[i].own_dm);
            chk("tbl_dm_gnt", dm_gnt, tbl[i].own_dm);
            @(posedge clk); #1; if_req = 1'b0; dm_req = 1'b0; #1;
            chk("tbl_mem_req", mem_req, 1'b1);
            chk("tbl_mem_addr", mem_addr, tbl[i].own_dm ? tbl[i].da : tbl[i].ia);
            chk("tbl_mem_wstrb", {mem_we, mem_wstrb}, 5'b0);
            n = 0;
            while (!(if_rvalid || dm_rvalid) && n < 30) begin @(posedge clk); #2; n++; end
            chk("tbl_if_rvalid", if_rvalid, !tbl[i].own_dm);
            chk("tbl_dm_rvalid", dm_rvalid, tbl[i].own_dm);
            chk("tbl_err", tbl[i].own_dm ? dm_err : if_err, tbl[i].err);
            chk("tbl_rdata", tbl[i].own_dm ? dm_rdata : if_rdata,
                tbl[i].err ? 32'h0 : init_word(tbl[i].own_dm ? tbl[i].da : tbl[i].ia));
            @(posedge clk); #2;
            chk("tbl_rvalid_pulse", {if_rvalid, dm_rvalid}, 2'b00);
        end

        // IF read with ack three cycles after mem_req.
        phys_mem[32'h10] = 32'h0051_3093;
        force_ackc = 4;
        @(posedge clk); #1; if_req = 1'b1; if_addr = 32'h10; #1;
        chk("a_if_gnt", if_gnt, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1; if_req = 1'b0; #1;
            chk("a_mem_req_hi", mem_req, 1'b1);
            chk("a_no_rvalid", if_rvalid, 1'b0);
        end
        @(posedge clk); #2;
        chk("a_mem_req_lo", mem_req, 1'b0);
        chk("a_if_rvalid", if_rvalid, 1'b1);
        chk("a_if_rdata", if_rdata, 32'h0051_3093);
        chk("a_if_err", if_err, 1'b0);
        @(posedge clk); #2;
        chk("a_if_rvalid_end", if_rvalid, 1'b0);

        // DM partial store.
        force_ackc = 3;
        @(posedge clk); #1;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'b0011;
        #1; chk("b_dm_gnt", dm_gnt, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1; dm_req = 1'b0; dm_wdata = 32'h0; dm_wstrb = 4'h0; #1;
            chk("b_mem_fields", {mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata},
                {1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF});
        end
        @(posedge clk); #2;
        chk("b_dm_rvalid", {dm_rvalid, dm_err, if_rvalid}, 3'b100);
        chk("b_phys", phys_rd(32'h100), merge(init_word(32'h100), 32'hDEAD_BEEF, 4'b0011));
        dm_we = 1'b0;

        // Timeout with no ack, then a normal IF fetch.
        force_ackc = 20;
        @(posedge clk); #1; dm_req = 1'b1; dm_addr = 32'h200; #1;
        chk("c_dm_gnt", dm_gnt, 1'b1);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1; dm_req = 1'b0; #1;
            if (!mem_req) break;
            cnt++;
        end
        chk("c_req_cycles", cnt, TO);
        chk("c_dm_result", {dm_rvalid, dm_err, dm_rdata}, {1'b1, 1'b1, 32'h0});
        force_ackc = 2;
        @(posedge clk); #1; if_req = 1'b1; if_addr = 32'h300; #1;
        chk("c_if_gnt", if_gnt, 1'b1);
        @(posedge clk); #1; if_req = 1'b0;
        n = 0;
        while (!if_rvalid && n < 20) begin @(posedge clk); #2; n++; end
        chk("c_if_result", {if_rvalid, if_err, if_rdata}, {1'b1, 1'b0, init_word(32'h300)});

        // Stray ack while idle.
        @(posedge clk); #1; inject_ack = 1'b1;
        @(posedge clk); #1; inject_ack = 1'b0; #1;
        chk("d_stray", {if_rvalid, dm_rvalid, mem_req}, 3'b000);
        @(posedge clk); #2;
        chk("d_stray2", {if_rvalid, dm_rvalid, mem_req}, 3'b000);

        // Reset in the middle of an IF access.
        force_ackc = 20;
        @(posedge clk); #1; if_req = 1'b1; if_addr = 32'h400; #1;
        chk("e_if_gnt", if_gnt, 1'b1);
        @(posedge clk); #1; if_req = 1'b0; #1;
        chk("e_mem_req", mem_req, 1'b1);
        #2; rstn = 1'b0; if_req = 1'b1; dm_req = 1'b1; if_addr = 32'h404;
        dm_addr = 32'h2000_0500; dm_we = 1'b0;
        #1;
        chk("e_async_drop", mem_req, 1'b0);
        chk("e_gnt_masked", {if_gnt, dm_gnt}, 2'b00);
        force_ackc = 2;
        repeat (2) @(posedge clk);
        #3; rstn = 1'b1; #1;
        chk("e_tie_dm", {if_gnt, dm_gnt}, 2'b01);
        @(posedge clk); #1; if_req = 1'b0; dm_req = 1'b0;
        seen_if = 1'b0; got_dm = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #2;
            if (if_rvalid) seen_if = 1'b1;
            if (dm_rvalid) got_dm = 1'b1;
        end
        chk("e_no_if_rvalid", seen_if, 1'b0);
        chk("e_dm_done", got_dm, 1'b1);

        // Random concurrent traffic against the reference model.
        force_ackc = 0;
        fork
            if_proc(40);
            dm_proc(40);
        join
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
